// File: rtl/pipe_pkg.sv
// Shared opcode, field-encoding and control-bundle definitions for the ID/EX control path.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] mem_to_reg;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle plus source-usage and jump flags.
// JAL support is selected by PIPE_CTRL_JAL_EN.
module ctrl_decode
  import pipe_pkg::*;
(
  input  logic [5:0]   i_opcode,
  output ctrl_bundle_t o_ctrl,
  output logic         o_uses_rs,
  output logic         o_uses_rt,
  output logic         o_is_jump
);

  always_comb begin
    o_ctrl    = CTRL_BUBBLE;
    o_uses_rs = 1'b0;
    o_uses_rt = 1'b0;
    o_is_jump = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.reg_dst   = RD_RD;
        o_ctrl.alu_op    = ALU_FUNCT;
        o_ctrl.reg_write = 1'b1;
        o_uses_rs        = 1'b1;
        o_uses_rt        = 1'b1;
      end
      OP_LW: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = MTR_MEM;
        o_ctrl.reg_write  = 1'b1;
        o_uses_rs         = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_uses_rs        = 1'b1;
        o_uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALU_SUB;
        o_uses_rs     = 1'b1;
        o_uses_rt     = 1'b1;
      end
      OP_BNE: begin
        o_ctrl.branch    = 1'b1;
        o_ctrl.branch_ne = 1'b1;
        o_ctrl.alu_op    = ALU_SUB;
        o_uses_rs        = 1'b1;
        o_uses_rt        = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_uses_rs        = 1'b1;
      end
      OP_J: o_is_jump = 1'b1;
`ifdef PIPE_CTRL_JAL_EN
      OP_JAL: begin
        o_ctrl.reg_dst    = RD_R31;
        o_ctrl.mem_to_reg = MTR_PC4;
        o_ctrl.reg_write  = 1'b1;
        o_is_jump         = 1'b1;
      end
`endif
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage decode into a registered ID/EX bundle, with load-use, branch-flush and stall control.
// Optional JAL decode enabled by defining PIPE_CTRL_JAL_EN.
module pipe_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             branch_taken_i,
  input  logic             ext_stall_i,
  output logic [1:0]       ex_reg_dst_o,
  output logic [1:0]       ex_alu_op_o,
  output logic             ex_alu_src_o,
  output logic             ex_branch_o,
  output logic             ex_branch_ne_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             ex_reg_write_o,
  output logic             ex_illegal_o,
  output logic [1:0]       ex_mem_to_reg_o,
  output logic [REG_W-1:0] ex_rt_o,
  output logic             id_jump_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_bundle_t     w_dec;
  logic             w_uses_rs;
  logic             w_uses_rt;
  logic             w_is_jump;
  logic             w_hazard;
  ctrl_bundle_t     r_ex;
  logic [REG_W-1:0] r_ex_rt;
  logic [CNT_W-1:0] r_bubble_cnt;

  ctrl_decode u_decode (
    .i_opcode  (opcode_i),
    .o_ctrl    (w_dec),
    .o_uses_rs (w_uses_rs),
    .o_uses_rt (w_uses_rt),
    .o_is_jump (w_is_jump)
  );

  // Only registered EX state feeds the hazard compare, so no combinational loop exists.
  assign w_hazard = r_ex.mem_read && (r_ex_rt != '0) &&
                    ((w_uses_rs && (r_ex_rt == rs_i)) || (w_uses_rt && (r_ex_rt == rt_i)));

  always_comb begin
    id_jump_o    = 1'b0;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    stall_o      = 1'b0;
    if (rst_n && !ext_stall_i) begin
      if (branch_taken_i) begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b1;
      end else if (w_hazard) begin
        stall_o = 1'b1;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        id_jump_o    = w_is_jump;
        ifid_flush_o = w_is_jump;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex         <= CTRL_BUBBLE;
      r_ex_rt      <= '0;
      r_bubble_cnt <= '0;
    end else if (!ext_stall_i) begin
      if (branch_taken_i || w_hazard) begin
        r_ex         <= CTRL_BUBBLE;
        r_ex_rt      <= '0;
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end else begin
        r_ex    <= w_dec;
        r_ex_rt <= rt_i;
      end
    end
  end

  assign ex_reg_dst_o    = r_ex.reg_dst;
  assign ex_alu_op_o     = r_ex.alu_op;
  assign ex_alu_src_o    = r_ex.alu_src;
  assign ex_branch_o     = r_ex.branch;
  assign ex_branch_ne_o  = r_ex.branch_ne;
  assign ex_mem_read_o   = r_ex.mem_read;
  assign ex_mem_write_o  = r_ex.mem_write;
  assign ex_reg_write_o  = r_ex.reg_write;
  assign ex_illegal_o    = r_ex.illegal;
  assign ex_mem_to_reg_o = r_ex.mem_to_reg;
  assign ex_rt_o         = r_ex_rt;
  assign bubble_cnt_o    = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: a per-cycle reference model plus hand-computed spot checks.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic [4:0] rs = 5'd0;
  logic [4:0] rt = 5'd0;
  logic       br = 1'b0;
  logic       st = 1'b0;

  always #5 clk = ~clk;

  logic [1:0]  a_reg_dst, a_alu_op, a_mtr, b_reg_dst, b_alu_op, b_mtr;
  logic        a_alu_src, a_br, a_bne, a_mr, a_mw, a_rw, a_ill;
  logic        b_alu_src, b_br, b_bne, b_mr, b_mw, b_rw, b_ill;
  logic [4:0]  a_rt, b_rt;
  logic        a_jump, a_pcw, a_ifw, a_flush, a_stall;
  logic        b_jump, b_pcw, b_ifw, b_flush, b_stall;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  pipe_ctrl_unit u_dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .rs_i(rs), .rt_i(rt),
    .branch_taken_i(br), .ext_stall_i(st),
    .ex_reg_dst_o(a_reg_dst), .ex_alu_op_o(a_alu_op), .ex_alu_src_o(a_alu_src),
    .ex_branch_o(a_br), .ex_branch_ne_o(a_bne), .ex_mem_read_o(a_mr),
    .ex_mem_write_o(a_mw), .ex_reg_write_o(a_rw), .ex_illegal_o(a_ill),
    .ex_mem_to_reg_o(a_mtr), .ex_rt_o(a_rt), .id_jump_o(a_jump),
    .pc_write_o(a_pcw), .ifid_write_o(a_ifw), .ifid_flush_o(a_flush),
    .stall_o(a_stall), .bubble_cnt_o(a_cnt)
  );

  pipe_ctrl_unit #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .rs_i(rs), .rt_i(rt),
    .branch_taken_i(br), .ext_stall_i(st),
    .ex_reg_dst_o(b_reg_dst), .ex_alu_op_o(b_alu_op), .ex_alu_src_o(b_alu_src),
    .ex_branch_o(b_br), .ex_branch_ne_o(b_bne), .ex_mem_read_o(b_mr),
    .ex_mem_write_o(b_mw), .ex_reg_write_o(b_rw), .ex_illegal_o(b_ill),
    .ex_mem_to_reg_o(b_mtr), .ex_rt_o(b_rt), .id_jump_o(b_jump),
    .pc_write_o(b_pcw), .ifid_write_o(b_ifw), .ifid_flush_o(b_flush),
    .stall_o(b_stall), .bubble_cnt_o(b_cnt)
  );

  // Bundle view order: reg_dst, alu_op, mem_to_reg, alu_src, branch, branch_ne, mem_read, mem_write, reg_write, illegal
  wire [12:0] a_ex = {a_reg_dst, a_alu_op, a_mtr, a_alu_src, a_br, a_bne, a_mr, a_mw, a_rw, a_ill};
  wire [12:0] b_ex = {b_reg_dst, b_alu_op, b_mtr, b_alu_src, b_br, b_bne, b_mr, b_mw, b_rw, b_ill};
  wire [4:0]  a_id = {a_jump, a_pcw, a_ifw, a_flush, a_stall};
  wire [4:0]  b_id = {b_jump, b_pcw, b_ifw, b_flush, b_stall};

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [12:0] ref_decode(input logic [5:0] op);
    case (op)
      6'b000000: return 13'b01_10_00_0_0_0_0_0_1_0;
      6'b100011: return 13'b00_00_01_1_0_0_1_0_1_0;
      6'b101011: return 13'b00_00_00_1_0_0_0_1_0_0;
      6'b000100: return 13'b00_01_00_0_1_0_0_0_0_0;
      6'b000101: return 13'b00_01_00_0_1_1_0_0_0_0;
      6'b001000: return 13'b00_00_00_1_0_0_0_0_1_0;
      6'b000010: return 13'b0;
`ifdef PIPE_CTRL_JAL_EN
      6'b000011: return 13'b10_00_10_0_0_0_0_0_1_0;
`endif
      default:   return 13'b1;
    endcase
  endfunction

  function automatic bit ref_jump(input logic [5:0] op);
`ifdef PIPE_CTRL_JAL_EN
    return (op == 6'b000010) || (op == 6'b000011);
`else
    return op == 6'b000010;
`endif
  endfunction

  function automatic bit reads_rs(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000};
  endfunction

  function automatic bit reads_rt(input logic [5:0] op);
    return op inside {6'b000000, 6'b101011, 6'b000100, 6'b000101};
  endfunction

  logic [12:0] m_ex;
  logic [4:0]  m_rt;
  int          m_cnt, m_cnt2;
  bit          m_valid = 1'b0;

  // Outputs are compared, then the model advances to the state the next edge must produce.
  always @(negedge clk) begin
    logic [4:0] e_id;
    bit hz;
    hz = m_valid && m_ex[3] && (m_rt != 0) &&
         ((reads_rs(opcode) && m_rt == rs) || (reads_rt(opcode) && m_rt == rt));
    if (!rst_n)  e_id = 5'b00000;
    else if (st) e_id = 5'b00000;
    else if (br) e_id = 5'b01110;
    else if (hz) e_id = 5'b00001;
    else         e_id = {ref_jump(opcode), 1'b1, 1'b1, ref_jump(opcode), 1'b0};
    if (m_valid) begin
      chk("model_ex", {19'd0, a_ex}, {19'd0, m_ex});
      chk("model_rt", {27'd0, a_rt}, {27'd0, m_rt});
      chk("model_cnt", {16'd0, a_cnt}, m_cnt);
      chk("model_id", {27'd0, a_id}, {27'd0, e_id});
      chk("model2_ex", {19'd0, b_ex}, {19'd0, m_ex});
      chk("model2_cnt", {30'd0, b_cnt}, m_cnt2);
      chk("model2_id", {27'd0, b_id}, {27'd0, e_id});
    end
    if (!rst_n) begin
      m_ex = '0; m_rt = '0; m_cnt = 0; m_cnt2 = 0; m_valid = 1'b1;
    end else if (!m_valid || st) begin
    end else if (br || hz) begin
      m_ex = '0; m_rt = '0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m_ex = ref_decode(opcode);
      m_rt = rt;
    end
  end

  task automatic step(input logic rn, input logic [5:0] op, input logic [4:0] s,
                      input logic [4:0] t, input logic b, input logic x);
    @(posedge clk); #1;
    rst_n = rn; opcode = op; rs = s; rt = t; br = b; st = x;
    @(negedge clk); #1;
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, JAL = 6'b000011;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(0, R, 0, 0, 0, 0);
    step(0, R, 0, 0, 0, 0);
    chk("rst_ex", {19'd0, a_ex}, 32'd0);
    chk("rst_cnt", {16'd0, a_cnt}, 32'd0);
    chk("rst_pcw", {31'd0, a_pcw}, 32'd0);

    // Load-use: LW $9 then R-type reading $9.
    step(1, LW, 0, 9, 0, 0);
    chk("lw_pcw", {31'd0, a_pcw}, 32'd1);
    step(1, R, 9, 10, 0, 0);
    chk("lu_stall", {31'd0, a_stall}, 32'd1);
    chk("lu_pcw", {31'd0, a_pcw}, 32'd0);
    step(1, R, 9, 10, 0, 0);
    chk("lu_bubble_ex", {19'd0, a_ex}, 32'd0);
    chk("lu_cnt", {16'd0, a_cnt}, 32'd1);
    step(1, ADDI, 1, 2, 0, 0);
    chk("lu_regdst", {30'd0, a_reg_dst}, 32'd1);
    chk("lu_aluop", {30'd0, a_alu_op}, 32'd2);

    // $zero destination never hazards.
    step(1, LW, 0, 0, 0, 0);
    step(1, R, 0, 0, 0, 0);
    chk("zero_stall", {31'd0, a_stall}, 32'd0);
    chk("zero_cnt", {16'd0, a_cnt}, 32'd1);

    // Branch wins over a pending hazard.
    step(1, LW, 0, 5, 0, 0);
    step(1, SW, 5, 6, 1, 0);
    chk("brhz_flush", {31'd0, a_flush}, 32'd1);
    chk("brhz_stall", {31'd0, a_stall}, 32'd0);
    step(1, ADDI, 1, 3, 0, 0);
    chk("brhz_cnt", {16'd0, a_cnt}, 32'd2);
    chk("brhz_ex", {19'd0, a_ex}, 32'd0);

    // External stall freezes everything, including a taken branch.
    repeat (3) step(1, R, 1, 2, 1, 1);
    chk("st_flush", {31'd0, a_flush}, 32'd0);
    chk("st_alusrc", {31'd0, a_alu_src}, 32'd1);
    chk("st_cnt", {16'd0, a_cnt}, 32'd2);
    step(1, R, 1, 2, 1, 0);
    chk("rel_flush", {31'd0, a_flush}, 32'd1);
    step(1, J, 0, 0, 0, 0);
    chk("rel_cnt", {16'd0, a_cnt}, 32'd3);
    chk("j_jump", {31'd0, a_jump}, 32'd1);
    chk("j_flush", {31'd0, a_flush}, 32'd1);

    step(1, JAL, 0, 0, 0, 0);
    chk("j_cnt", {16'd0, a_cnt}, 32'd3);
    step(1, 6'b111111, 0, 0, 0, 0);
`ifdef PIPE_CTRL_JAL_EN
    chk("jal_ex", {19'd0, a_ex}, {19'd0, 13'b10_00_10_0_0_0_0_0_1_0});
`else
    chk("jal_ex", {19'd0, a_ex}, 32'd1);
`endif
    step(1, ADDI, 0, 0, 0, 0);
    chk("ill_ex", {19'd0, a_ex}, 32'd1);

    // Five load-use hazards saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      step(1, LW, 0, 7, 0, 0);
      step(1, R, 7, 1, 0, 0);
      step(1, R, 7, 1, 0, 0);
    end
    chk("sat_cnt2", {30'd0, b_cnt}, 32'd3);
    chk("sat_cnt", {16'd0, a_cnt}, 32'd8);

    // Reset in the middle of a stall.
    step(1, LW, 0, 4, 0, 0);
    step(1, R, 4, 1, 0, 0);
    chk("rs_pre_stall", {31'd0, a_stall}, 32'd1);
    step(0, R, 4, 1, 0, 0);
    chk("rs_id", {27'd0, a_id}, 32'd0);
    step(0, R, 4, 1, 0, 0);
    chk("rs_ex", {19'd0, a_ex}, 32'd0);
    chk("rs_cnt", {16'd0, a_cnt}, 32'd0);
    chk("rs_cnt2", {30'd0, b_cnt}, 32'd0);
    step(1, R, 4, 1, 0, 0);
    chk("rs_post_stall", {31'd0, a_stall}, 32'd0);
    chk("rs_post_pcw", {31'd0, a_pcw}, 32'd1);
    step(1, ADDI, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
